// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: opcodes, funct3 access-size encodings, LSU state
// encoding and funct3 legality/alignment helpers.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes never misalign.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding data-memory port between the LSU (master) and memory (slave).
interface load_store_unit_if;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wstrb_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;

  modport master (
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
    input  mem_ack_in, mem_rdata_in
  );

  modport slave (
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
    output mem_ack_in, mem_rdata_in
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Combinational load aligner: picks the byte/halfword lane from the read word
// and sign- or zero-extends it to 32 bits according to funct3.
module lsu_load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    // Only addr[1] picks the halfword lane; addr[0] is an alignment concern.
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data_o = {24'd0, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_HU:   data_o = {16'd0, half_v};
      F3_W:    data_o = rdata_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one instruction per handshake, single-outstanding memory port,
// registered writeback packet. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import riscv_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [6:0]                opcode_in,
  input  logic [2:0]                funct3_in,
  input  logic [31:0]               alu_result_in,
  input  logic [31:0]               rs2_value_in,
  input  logic [4:0]                rd_in,
  load_store_unit_if.master         mem,
  output logic                      wb_valid_out,
  input  logic                      wb_ready_in,
  output logic                      wb_we_out,
  output logic [4:0]                wb_rd_out,
  output logic [31:0]               wb_data_out,
  output logic                      lsu_err_out
);

  lsu_state_e  state_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        wb_valid_q, wb_we_q, lsu_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;

  logic        is_load_d, is_store_d, err_d;
  logic [31:0] wdata_d;
  logic [3:0]  strb_d;
  logic [31:0] load_data;

  always_comb begin
    is_load_d  = (opcode_in == OP_LOAD);
    is_store_d = (opcode_in == OP_STORE);
    err_d      = (is_load_d  && !load_f3_legal(funct3_in)) ||
                 (is_store_d && !store_f3_legal(funct3_in));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((is_load_d || is_store_d) && misaligned(funct3_in, alu_result_in[1:0]))
      err_d = 1'b1;
`endif
    case (funct3_in)
      F3_B: begin
        wdata_d = {4{rs2_value_in[7:0]}};
        strb_d  = 4'b0001 << alu_result_in[1:0];
      end
      F3_H: begin
        wdata_d = {2{rs2_value_in[15:0]}};
        strb_d  = 4'b0011 << {alu_result_in[1], 1'b0};
      end
      default: begin
        wdata_d = rs2_value_in;
        strb_d  = 4'b1111;
      end
    endcase
  end

  lsu_load_extend u_load_extend (
    .rdata_i   (mem.mem_rdata_in),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      lsu_err_q   <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      funct3_q    <= 3'd0;
      addr_lo_q   <= 2'd0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (valid_in) begin
            funct3_q  <= funct3_in;
            addr_lo_q <= alu_result_in[1:0];
            wb_rd_q   <= rd_in;
            if ((is_load_d || is_store_d) && !err_d) begin
              state_q     <= LSU_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_d;
              mem_addr_q  <= {alu_result_in[31:2], 2'b00};
              mem_wdata_q <= is_store_d ? wdata_d : 32'd0;
              mem_wstrb_q <= is_store_d ? strb_d : 4'd0;
              wb_we_q     <= is_load_d && (rd_in != 5'd0);
              lsu_err_q   <= 1'b0;
            end else begin
              // Pass-through and rejected accesses skip the memory port entirely.
              state_q    <= LSU_RESP;
              wb_valid_q <= 1'b1;
              lsu_err_q  <= err_d;
              wb_we_q    <= !err_d && (rd_in != 5'd0);
              wb_data_q  <= err_d ? 32'd0 : alu_result_in;
            end
          end
        end
        LSU_REQ: begin
          if (mem.mem_ack_in) begin
            state_q    <= LSU_RESP;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_data_q  <= mem_we_q ? 32'd0 : load_data;
          end
        end
        LSU_RESP: begin
          if (wb_ready_in) begin
            state_q    <= LSU_IDLE;
            wb_valid_q <= 1'b0;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign ready_out         = (state_q == LSU_IDLE);
  assign mem.mem_req_out   = mem_req_q;
  assign mem.mem_we_out    = mem_we_q;
  assign mem.mem_addr_out  = mem_addr_q;
  assign mem.mem_wdata_out = mem_wdata_q;
  assign mem.mem_wstrb_out = mem_wstrb_q;
  assign wb_valid_out      = wb_valid_q;
  assign wb_we_out         = wb_we_q;
  assign wb_rd_out         = wb_rd_q;
  assign wb_data_out       = wb_data_q;
  assign lsu_err_out       = lsu_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: pass-through, loads, stores, ack delay,
// backpressure, illegal funct3, reset in REQ and misalignment handling.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [6:0]  opcode_in = 7'd0;
  logic [2:0]  funct3_in = 3'd0;
  logic [31:0] alu_result_in = 32'd0;
  logic [31:0] rs2_value_in = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        wb_valid_out, wb_ready_in, wb_we_out, lsu_err_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;

  int passed = 0;
  int total  = 0;

  load_store_unit_if mem_if();

  load_store_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .opcode_in     (opcode_in),
    .funct3_in     (funct3_in),
    .alu_result_in (alu_result_in),
    .rs2_value_in  (rs2_value_in),
    .rd_in         (rd_in),
    .mem           (mem_if.master),
    .wb_valid_out  (wb_valid_out),
    .wb_ready_in   (wb_ready_in),
    .wb_we_out     (wb_we_out),
    .wb_rd_out     (wb_rd_out),
    .wb_data_out   (wb_data_out),
    .lsu_err_out   (lsu_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accept edge, then withdraw and scramble inputs.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd);
    valid_in = 1'b1; opcode_in = op; funct3_in = f3;
    alu_result_in = alu; rs2_value_in = rs2; rd_in = rd;
    step();
    valid_in = 1'b0; alu_result_in = 32'hDEAD_0000; rs2_value_in = 32'hFFFF_FFFF;
    funct3_in = 3'b111; rd_in = 5'd31;
  endtask

  task automatic ack(input logic [31:0] rdata);
    mem_if.mem_ack_in = 1'b1; mem_if.mem_rdata_in = rdata;
    step();
    mem_if.mem_ack_in = 1'b0; mem_if.mem_rdata_in = 32'h0BAD_0BAD;
  endtask

  task automatic consume();
    wb_ready_in = 1'b1;
    step();
    wb_ready_in = 1'b0;
  endtask

  initial begin
    wb_ready_in = 1'b0;
    mem_if.mem_ack_in = 1'b0;
    mem_if.mem_rdata_in = 32'd0;

    #3;
    check("rst_ready", ready_out, 1);
    check("rst_req", mem_if.mem_req_out, 0);
    check("rst_wb_valid", wb_valid_out, 0);
    check("rst_addr", mem_if.mem_addr_out, 0);
    check("rst_wb_data", wb_data_out, 0);
    #10 rst_n = 1'b1;
    step();

    // Pass-through: writeback one cycle after accept, no memory request.
    issue(OP_REG, 3'd0, 32'h0000_0042, 32'd0, 5'd5);
    check("pt_valid", wb_valid_out, 1);
    check("pt_data", wb_data_out, 32'h42);
    check("pt_we", wb_we_out, 1);
    check("pt_rd", wb_rd_out, 5);
    check("pt_req", mem_if.mem_req_out, 0);
    check("pt_err", lsu_err_out, 0);
    check("pt_ready", ready_out, 0);
    consume();
    check("pt_done_valid", wb_valid_out, 0);
    check("pt_done_ready", ready_out, 1);

    // LB sign-extension of byte 3.
    issue(OP_LOAD, F3_B, 32'h0000_1003, 32'd0, 5'd7);
    check("lb_req", mem_if.mem_req_out, 1);
    check("lb_addr", mem_if.mem_addr_out, 32'h1000);
    check("lb_we", mem_if.mem_we_out, 0);
    check("lb_strb", mem_if.mem_wstrb_out, 0);
    check("lb_novalid", wb_valid_out, 0);
    ack(32'h80FF_FF7F);
    check("lb_valid", wb_valid_out, 1);
    check("lb_data", wb_data_out, 32'hFFFF_FF80);
    check("lb_wbwe", wb_we_out, 1);
    check("lb_req_drop", mem_if.mem_req_out, 0);
    consume();

    // LBU on the same word.
    issue(OP_LOAD, F3_BU, 32'h0000_1003, 32'd0, 5'd7);
    ack(32'h80FF_FF7F);
    check("lbu_data", wb_data_out, 32'h0000_0080);
    consume();

    // LH upper half, sign-extended.
    issue(OP_LOAD, F3_H, 32'h0000_1002, 32'd0, 5'd8);
    ack(32'h8123_4567);
    check("lh_data", wb_data_out, 32'hFFFF_8123);
    consume();

    // SH to upper half.
    issue(OP_STORE, F3_H, 32'h0000_2002, 32'h1234_ABCD, 5'd9);
    check("sh_req", mem_if.mem_req_out, 1);
    check("sh_we", mem_if.mem_we_out, 1);
    check("sh_addr", mem_if.mem_addr_out, 32'h2000);
    check("sh_wdata", mem_if.mem_wdata_out, 32'hABCD_ABCD);
    check("sh_strb", mem_if.mem_wstrb_out, 4'b1100);
    ack(32'd0);
    check("sh_valid", wb_valid_out, 1);
    check("sh_wbwe", wb_we_out, 0);
    check("sh_err", lsu_err_out, 0);
    consume();

    // SB to byte 1.
    issue(OP_STORE, F3_B, 32'h0000_1001, 32'h0000_0055, 5'd1);
    check("sb_wdata", mem_if.mem_wdata_out, 32'h5555_5555);
    check("sb_strb", mem_if.mem_wstrb_out, 4'b0010);
    ack(32'd0);
    consume();

    // Ack held off 3 cycles; writeback in cycle 5.
    issue(OP_LOAD, F3_W, 32'h0000_4000, 32'd0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      check("dly_req", mem_if.mem_req_out, 1);
      check("dly_addr", mem_if.mem_addr_out, 32'h4000);
      check("dly_novalid", wb_valid_out, 0);
      step();
    end
    check("dly_req_c4", mem_if.mem_req_out, 1);
    ack(32'hDEAD_BEEF);
    check("dly_valid_c5", wb_valid_out, 1);
    check("dly_data", wb_data_out, 32'hDEAD_BEEF);
    check("dly_rd", wb_rd_out, 3);

    // Backpressure: packet holds for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", wb_valid_out, 1);
      check("bp_data", wb_data_out, 32'hDEAD_BEEF);
      check("bp_ready", ready_out, 0);
    end
    consume();
    check("bp_ready_after", ready_out, 1);

    // Illegal load funct3.
    issue(OP_LOAD, 3'b011, 32'h0000_1000, 32'd0, 5'd4);
    check("ill_valid", wb_valid_out, 1);
    check("ill_err", lsu_err_out, 1);
    check("ill_we", wb_we_out, 0);
    check("ill_data", wb_data_out, 0);
    check("ill_req", mem_if.mem_req_out, 0);
    consume();

    // Illegal store funct3.
    issue(OP_STORE, 3'b100, 32'h0000_1000, 32'd0, 5'd4);
    check("ills_err", lsu_err_out, 1);
    check("ills_req", mem_if.mem_req_out, 0);
    consume();

    // Reset asserted while in REQ.
    issue(OP_LOAD, F3_W, 32'h0000_5000, 32'd0, 5'd6);
    check("rreq_req", mem_if.mem_req_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rreq_req_drop", mem_if.mem_req_out, 0);
    check("rreq_addr", mem_if.mem_addr_out, 0);
    check("rreq_ready", ready_out, 1);
    check("rreq_wb_rd", wb_rd_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Misaligned word load.
    issue(OP_LOAD, F3_W, 32'h0000_3001, 32'd0, 5'd2);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", lsu_err_out, 1);
    check("mis_req", mem_if.mem_req_out, 0);
    check("mis_we", wb_we_out, 0);
    consume();
`else
    check("mis_req", mem_if.mem_req_out, 1);
    check("mis_addr", mem_if.mem_addr_out, 32'h3000);
    ack(32'hCAFE_F00D);
    check("mis_err", lsu_err_out, 0);
    check("mis_data", wb_data_out, 32'hCAFE_F00D);
    consume();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage directly downstream of the ALU. It accepts one instruction per handshake from the execute stage, using the ALU result as the effective address for loads and stores. It drives a single-outstanding-request data-memory port, aligns and sign/zero-extends load data, and presents a registered writeback packet downstream. Non-memory instructions pass through with their ALU result as writeback data.

## Interface
- No parameters. Data width is fixed at 32 and register index width at 5.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: the execute stage presents an instruction.
- `ready_out` out 1: the block accepts the instruction. Asserted iff the state is IDLE.
- `opcode_in` in 7: 7'b0000011 is a load, 7'b0100011 is a store, any other value is a pass-through.
- `funct3_in` in 3: access size and sign.
- `alu_result_in` in 32: effective address, or the pass-through result.
- `rs2_value_in` in 32: store data.
- `rd_in` in 5: destination register.
- `mem_req_out` out 1: memory request. Held high until acknowledged.
- `mem_we_out` out 1: 1 for a store.
- `mem_addr_out` out 32: word-aligned address, {addr[31:2], 2'b00}.
- `mem_wdata_out` out 32: lane-replicated store data.
- `mem_wstrb_out` out 4: byte enables. All zero for loads.
- `mem_ack_in` in 1: memory completes the request. Read data is valid in the same cycle.
- `mem_rdata_in` in 32: read word.
- `wb_valid_out` out 1: writeback packet valid.
- `wb_ready_in` in 1: the writeback stage consumes the packet.
- `wb_we_out` out 1: write the register file. 0 for stores, errors, and rd=0.
- `wb_rd_out` out 5: destination register.
- `wb_data_out` out 32: writeback value.
- `lsu_err_out` out 1: illegal funct3 or misaligned access. Qualified by `wb_valid_out`.

## Operation
- The FSM has three states: IDLE, REQ, RESP.
- **IDLE:**
  - On `valid_in` (ready is high), capture opcode, funct3, address, rs2 and rd.
  - A legal load or store goes to REQ. Everything else goes to RESP.
- **REQ:**
  - `mem_req_out` is 1, and the address, write data and strobe outputs are stable.
  - On `mem_ack_in`, capture the extended load data and go to RESP.
  - While ack is low, stay in REQ.
- **RESP:**
  - `wb_valid_out` is 1 and the packet is stable.
  - On `wb_ready_in`, go to IDLE.
- **Store data:**
  - SB (000): wdata = {4{rs2[7:0]}}, strb = 4'b0001 << addr[1:0].
  - SH (001): wdata = {2{rs2[15:0]}}, strb = 4'b0011 << {addr[1],1'b0}.
  - SW (010): wdata = rs2, strb = 4'b1111.
- **Loads:**
  - LB (000) and LBU (100) select byte addr[1:0]. LB sign-extends, LBU zero-extends.
  - LH (001) and LHU (101) select halfword addr[1]. LH sign-extends, LHU zero-extends.
  - LW (010) takes the full word.
- **Illegal funct3:**
  - Loads: 011, 110, 111. Stores: 011 to 111.
  - No memory request is issued. Go straight to RESP with `lsu_err_out`=1, `wb_we_out`=0, and `wb_data_out`=0.
- **Pass-through:** `wb_data_out` = `alu_result_in` and `wb_we_out` = (rd≠0).
- **Misalignment:** behaviour depends on the macro. See Configuration.

## Timing
- **Reset values:**
  - State is IDLE.
  - `mem_req_out`, `mem_we_out`, `wb_valid_out`, `wb_we_out` and `lsu_err_out` are 0.
  - `mem_addr_out`, `mem_wdata_out`, `mem_wstrb_out`, `wb_rd_out` and `wb_data_out` are 0.
  - `ready_out` is 1.
- All outputs are driven from registers or the state register. There is no combinational path from any input to any output.
- **Latency** (accept in cycle 0):
  - Pass-through or error: `wb_valid_out` in cycle 1.
  - Memory access: `mem_req_out` in cycle 1. With ack in cycle 1+k, `wb_valid_out` appears in cycle 2+k.
- Throughput is at most one instruction every 2 cycles for pass-through.
- `mem_ack_in` and `mem_rdata_in` are ignored outside REQ.
- `wb_ready_in` is ignored outside RESP.
- Reset asserted in REQ abandons the request. `mem_req_out` drops immediately and the memory tolerates a withdrawn request.
- Reset asserted in RESP drops the packet.
- Inputs are sampled only on the accept edge. Later changes have no effect.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - Misaligned accesses are LH, LHU or SH with addr[0]=1, and LW or SW with addr[1:0]≠0.
  - These issue no memory request and go to RESP with `lsu_err_out`=1 and `wb_we_out`=0.
- **Undefined:**
  - The low address bits are ignored for size alignment: halfwords use addr[1] only, and words use lane 0.
  - The access proceeds and `lsu_err_out` flags only illegal funct3.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode constants OP_LOAD, OP_STORE, OP_IMM and OP_REG;
  - the funct3 size encodings;
  - the LSU state enum.
- The ALU uses the same opcode constants.
- Sub-module `lsu_load_extend` is purely combinational. It takes rdata, addr[1:0] and funct3, and produces the extended 32-bit value.

## Test plan
- **Pass-through:** opcode 0110011, alu=32'h0000_0042, rd=5.
  - Expect `wb_valid_out` in cycle 1 with data 32'h42, we=1, and no `mem_req_out`.
- **LB sign-extension:** addr=32'h1003, rdata=32'h80FF_FF7F.
  - Expect `mem_addr_out`=32'h1000 and data 32'hFFFF_FF80.
  - LBU on the same input gives 32'h0000_0080.
- **SH to upper half:** addr=32'h2002, rs2=32'h1234_ABCD.
  - Expect wdata=32'hABCD_ABCD, strb=4'b1100, and wb_we=0.
- **Ack delay:** ack held off for 3 cycles.
  - `mem_req_out` stays high with stable outputs.
  - `wb_valid_out` appears in cycle 5.
- **Backpressure:** `wb_ready_in`=0 for 4 cycles.
  - The packet holds and `ready_out` stays 0.
- **Reset mid-operation and misalignment:**
  - `rst_n` pulsed low in REQ: all outputs return to reset values asynchronously.
  - LW at 32'h3001 with the macro defined: `lsu_err_out`=1 and no request issued.
  - Same access with the macro undefined: request issued at 32'h3000.
